// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding, key code
// width, idle column pattern and small encode helpers.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned ROW_N = 4;
  localparam int unsigned COL_N = 4;

  localparam logic [COL_N-1:0] COL_IDLE = 4'b1110;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // Index of the lowest active-low row; only meaningful when some row is low.
  function automatic logic [1:0] lowest_low_row(input logic [ROW_N-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROW_N - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Active-low one-cold column drive for a column index.
  function automatic logic [COL_N-1:0] col_drive(input logic [1:0] idx);
    logic [COL_N-1:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs.
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset (outputs return to all-high / idle)
//   row_i  raw active-low rows from the pins
//   row_o  synchronized rows
module row_sync
  import keypad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_N-1:0] row_i,
  output logic [ROW_N-1:0] row_o
);

  logic [ROW_N-1:0] meta_q;
  logic [ROW_N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign row_o = sync_q;

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low keypad scanner with debounce and 4-bit key encoding.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   row_in     matrix rows, active-low, asynchronous
//   col_out    column drive, active-low, exactly one bit low
//   Dout       last accepted key code {row[1:0], col[1:0]}
//   key_valid  one-cycle strobe per accepted press
//   key_held   high from accepted press until accepted release
// SCAN_DIV must be >= 4 and DEBOUNCE_CNT >= 2.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_N-1:0] row_in,
  output logic [COL_N-1:0] col_out,
  output logic [KEY_W-1:0] Dout,
  output logic             key_valid,
  output logic             key_held
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CNT);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);

  state_e            state_q, state_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [COL_N-1:0]  col_out_q, col_out_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [1:0]        cap_row_q, cap_row_d;
  logic [1:0]        cap_col_q, cap_col_d;
  logic [KEY_W-1:0]  dout_q, dout_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

  logic [ROW_N-1:0]  row_s;
  logic              cap_low;
  logic [1:0]        col_next;

  row_sync u_row_sync (
    .clk   (clk),
    .rst   (rst),
    .row_i (row_in),
    .row_o (row_s)
  );

  // Captured key's row is still pulled low.
  assign cap_low  = ~row_s[cap_row_q];
  assign col_next = col_idx_q + 2'd1;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      col_out_q   <= COL_IDLE;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      cap_row_q   <= 2'd0;
      cap_col_q   <= 2'd0;
      dout_q      <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      col_out_q   <= col_out_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      cap_row_q   <= cap_row_d;
      cap_col_q   <= cap_col_d;
      dout_q      <= dout_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    col_out_d   = col_out_q;
    scan_cnt_d  = scan_cnt_q;
    db_cnt_d    = db_cnt_q;
    cap_row_d   = cap_row_q;
    cap_col_d   = cap_col_q;
    dout_d      = dout_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (row_s == 4'hF) begin
            col_idx_d = col_next;
            col_out_d = col_drive(col_next);
          end else begin
            // Column drive stays put so the key keeps pulling its row.
            cap_row_d = lowest_low_row(row_s);
            cap_col_d = col_idx_q;
            db_cnt_d  = '0;
            state_d   = ST_DEBOUNCE;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (!cap_low) begin
          state_d    = ST_SCAN;
          scan_cnt_d = '0;
          col_idx_d  = col_next;
          col_out_d  = col_drive(col_next);
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_PRESSED;
          dout_d      = {cap_row_q, cap_col_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      ST_PRESSED: begin
        if (!cap_low) begin
          state_d  = ST_RELEASE;
          db_cnt_d = '0;
        end
      end

      ST_RELEASE: begin
        if (cap_low) begin
          state_d = ST_PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_SCAN;
          key_held_d = 1'b0;
          scan_cnt_d = '0;
          col_idx_d  = col_next;
          col_out_d  = col_drive(col_next);
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  assign col_out   = col_out_q;
  assign Dout      = dout_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Self-checking bench for keypad_scan_encoder with a keypad matrix model and
// a streak-based behavioural reference of the scanner.
module tb_keypad_scan_encoder;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in = 4'hF;
  logic [3:0] col_out;
  logic [3:0] Dout;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;  // bit r*4+c: key (r,c) pressed

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int pulses = 0;
  int last_pulse_cycle = -1;

  // Reference model: phase 0 scanning, 1 qualifying a press, 2 key accepted.
  int         m_phase = 0;
  int         m_col = 0;
  int         m_timer = 0;
  int         m_row = 0;
  int         m_kcol = 0;
  int         m_streak = 0;
  logic [3:0] m_s1 = 4'hF;
  logic [3:0] m_s2 = 4'hF;
  logic [3:0] m_dout = 4'h0;
  logic       m_valid = 1'b0;
  logic       m_held = 1'b0;

  keypad_scan_encoder #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .Dout      (Dout),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] col_pattern(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic int lowest_low(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (!r[i]) return i;
    return 0;
  endfunction

  task automatic next_column();
    m_col   = (m_col + 1) % 4;
    m_timer = 0;
    m_phase = 0;
  endtask

  // Advance the reference by one clock edge given rst and the row pins seen at it.
  task automatic model_step(input logic rst_v, input logic [3:0] pin);
    logic [3:0] rs;
    rs      = m_s2;
    m_s2    = m_s1;
    m_s1    = pin;
    m_valid = 1'b0;
    if (rst_v) begin
      m_phase = 0; m_col = 0; m_timer = 0; m_row = 0; m_kcol = 0; m_streak = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_dout = 4'h0; m_held = 1'b0;
      return;
    end
    case (m_phase)
      0: begin
        m_timer++;
        if (m_timer == SD) begin
          m_timer = 0;
          if (rs == 4'hF) next_column();
          else begin
            m_phase = 1; m_row = lowest_low(rs); m_kcol = m_col; m_streak = 0;
          end
        end
      end
      1: begin
        if (!rs[m_row]) begin
          m_streak++;
          if (m_streak == DB) begin
            m_phase = 2; m_dout = 4'(m_row * 4 + m_kcol);
            m_valid = 1'b1; m_held = 1'b1; m_streak = 0;
          end
        end else next_column();
      end
      default: begin
        // Released after DB+1 consecutive high samples of the held row.
        if (rs[m_row]) m_streak++;
        else m_streak = 0;
        if (m_streak == DB + 1) begin
          m_held = 1'b0;
          next_column();
        end
      end
    endcase
  endtask

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  task automatic drive_rows();
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++) if (keys[rr * 4 + m_col]) r[rr] = 1'b0;
    row_in = r;
  endtask

  // One clock: advance the reference, update the matrix, score all outputs.
  task automatic tick();
    logic       rst_v;
    logic [3:0] pin;
    rst_v = rst;
    pin   = row_in;
    @(posedge clk);
    #1;
    cycle++;
    model_step(rst_v, pin);
    drive_rows();
    vectors += 4;
    if (col_out !== col_pattern(m_col)) begin
      miscompares++;
      $display("FAIL col_out @%0d: got %b expected %b", cycle, col_out, col_pattern(m_col));
    end
    if (Dout !== m_dout) begin
      miscompares++;
      $display("FAIL Dout @%0d: got %h expected %h", cycle, Dout, m_dout);
    end
    if (key_valid !== m_valid) begin
      miscompares++;
      $display("FAIL key_valid @%0d: got %b expected %b", cycle, key_valid, m_valid);
    end
    if (key_held !== m_held) begin
      miscompares++;
      $display("FAIL key_held @%0d: got %b expected %b", cycle, key_held, m_held);
    end
    if (key_valid === 1'b1) begin
      pulses++;
      last_pulse_cycle = cycle;
    end
  endtask

  task automatic wait_col_start(input int c, input string tag);
    int n;
    n = 0;
    while (!(m_phase == 0 && m_col == c && m_timer == 0) && n < 200) begin
      tick();
      n++;
    end
    if (!(m_phase == 0 && m_col == c && m_timer == 0)) begin
      miscompares++;
      $display("FAIL %s: column %0d scan start not reached in %0d cycles", tag, c, n);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (m_phase != 0 && n < 200) begin
      tick();
      n++;
    end
    if (m_phase != 0) begin
      miscompares++;
      $display("FAIL %s: scanning not resumed in %0d cycles", tag, n);
    end
  endtask

  task automatic set_keys(input logic [15:0] k);
    keys = k;
    drive_rows();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if (col_out !== 4'b1110 || Dout !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got col=%b dout=%h v=%b h=%b required 1110/0/0/0",
               col_out, Dout, key_valid, key_held);
    end
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      vectors++;
      if (col_out !== col_pattern((i / 4) % 4)) begin
        miscompares++;
        $display("FAIL rotation cycle %0d: got %b required %b", i, col_out, col_pattern((i / 4) % 4));
      end
    end
  endtask

  task automatic test_press();
    int p;
    wait_col_start(2, "press");
    p = cycle;
    pulses = 0;
    last_pulse_cycle = -1;
    set_keys(16'(1) << (1 * 4 + 2));
    repeat (60) tick();
    vectors += 5;
    if (pulses != 1) begin
      miscompares++; $display("FAIL press_pulses: got %0d required 1", pulses);
    end
    if (last_pulse_cycle != p + int'(SD) + int'(DB)) begin
      miscompares++;
      $display("FAIL press_latency: pulse at %0d required %0d", last_pulse_cycle, p + int'(SD) + int'(DB));
    end
    if (Dout !== 4'h6) begin
      miscompares++; $display("FAIL press_dout: got %h required 6", Dout);
    end
    if (key_held !== 1'b1) begin
      miscompares++; $display("FAIL press_held: got %b required 1", key_held);
    end
    if (col_out !== 4'b1011) begin
      miscompares++; $display("FAIL press_col_frozen: got %b required 1011", col_out);
    end
    set_keys('0);
    wait_idle("press_release");
    repeat (5) tick();
  endtask

  task automatic test_bounce();
    wait_col_start(2, "bounce");
    pulses = 0;
    set_keys(16'(1) << 6);
    repeat (3) tick();
    set_keys('0);
    repeat (2) tick();
    set_keys(16'(1) << 6);
    tick();
    vectors++;
    if (col_out !== 4'b0111) begin
      miscompares++; $display("FAIL bounce_resume_col: got %b required 0111", col_out);
    end
    repeat (2) tick();
    set_keys('0);
    repeat (30) tick();
    vectors += 2;
    if (pulses != 0) begin
      miscompares++; $display("FAIL bounce_pulses: got %0d required 0", pulses);
    end
    if (Dout !== 4'h6) begin
      miscompares++; $display("FAIL bounce_dout: got %h required 6", Dout);
    end
  endtask

  task automatic test_release_glitch();
    int n;
    wait_col_start(2, "glitch");
    set_keys(16'(1) << 6);
    n = 0;
    while (key_held !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    repeat (5) tick();
    pulses = 0;
    set_keys('0);
    repeat (3) tick();
    set_keys(16'(1) << 6);
    repeat (10) tick();
    vectors += 2;
    if (pulses != 0) begin
      miscompares++; $display("FAIL glitch_pulses: got %0d required 0", pulses);
    end
    if (key_held !== 1'b1) begin
      miscompares++; $display("FAIL glitch_held: got %b required 1", key_held);
    end
    set_keys('0);
    n = 0;
    while (key_held !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    vectors += 3;
    if (key_held !== 1'b0) begin
      miscompares++; $display("FAIL glitch_release_held: got %b required 0", key_held);
    end
    if (col_out !== 4'b0111) begin
      miscompares++; $display("FAIL glitch_release_col: got %b required 0111", col_out);
    end
    if (Dout !== 4'h6) begin
      miscompares++; $display("FAIL glitch_release_dout: got %h required 6", Dout);
    end
    repeat (5) tick();
  endtask

  task automatic test_multi_row();
    wait_col_start(3, "multi");
    pulses = 0;
    set_keys((16'(1) << 3) | (16'(1) << 11));
    repeat (30) tick();
    vectors += 2;
    if (pulses != 1) begin
      miscompares++; $display("FAIL multi_pulses: got %0d required 1", pulses);
    end
    if (Dout !== 4'h3) begin
      miscompares++; $display("FAIL multi_dout: got %h required 3", Dout);
    end
    set_keys('0);
    wait_idle("multi_release");
    wait_col_start(3, "corner");
    set_keys(16'(1) << 15);
    repeat (30) tick();
    vectors++;
    if (Dout !== 4'hF) begin
      miscompares++; $display("FAIL corner_dout: got %h required F", Dout);
    end
    set_keys('0);
    wait_idle("corner_release");
    vectors++;
    if (col_out !== 4'b1110) begin
      miscompares++; $display("FAIL corner_wrap_col: got %b required 1110", col_out);
    end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid_debounce();
    int c;
    int r;
    int n;
    c = int'($urandom_range(0, 3));
    r = int'($urandom_range(0, 3));
    wait_col_start(c, "rst_mid");
    pulses = 0;
    set_keys(16'(1) << (r * 4 + c));
    n = 0;
    while (!(m_phase == 1 && m_streak == 5) && n < 60) begin
      tick();
      n++;
    end
    if (!(m_phase == 1 && m_streak == 5)) begin
      miscompares++;
      $display("FAIL rst_mid: debounce count 5 not reached in %0d cycles", n);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (col_out !== 4'b1110 || Dout !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_values: got col=%b dout=%h v=%b h=%b required 1110/0/0/0",
               col_out, Dout, key_valid, key_held);
    end
    set_keys('0);
    repeat (20) tick();
    vectors++;
    if (pulses != 0) begin
      miscompares++; $display("FAIL rst_mid_pulses: got %0d required 0", pulses);
    end
  endtask

  task automatic test_random();
    logic [15:0] k;
    for (int it = 0; it < 12; it++) begin
      k = '0;
      k[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 1) == 1) k[$urandom_range(0, 15)] = 1'b1;
      repeat ($urandom_range(0, 12)) tick();
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        set_keys(k);
        repeat ($urandom_range(1, 6)) tick();
        set_keys('0);
        repeat ($urandom_range(1, 3)) tick();
      end
      set_keys(k);
      repeat ($urandom_range(0, 40)) tick();
      set_keys('0);
      wait_idle("random_release");
      repeat ($urandom_range(5, 20)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_release_glitch();
    test_multi_row();
    test_reset_mid_debounce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
